// File: rtl/csm_pkg.sv
// Shared types and helpers for the multi-port shared-register block with lock
// ownership. Operation and status encodings are part of the external interface.
package csm_pkg;

  typedef enum logic [1:0] {
    READ    = 2'd0,
    WRITE   = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    OK            = 2'd0,
    ERR_LOCKED    = 2'd1,
    ERR_NOT_HELD  = 2'd2,
    ERR_NOT_OWNER = 2'd3
  } status_t;

  // Index width that never collapses to zero bits for single-entry sets.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Outcome of an operation given the (post-expiry) lock state of its address.
  function automatic status_t lock_check(input op_t op, input logic locked,
                                         input logic owned);
    status_t st;
    st = OK;
    case (op)
      READ, WRITE, HOLD: st = (locked && !owned) ? ERR_LOCKED : OK;
      RELEASE: begin
        if (!locked)    st = ERR_NOT_HELD;
        else if (owned) st = OK;
        else            st = ERR_NOT_OWNER;
      end
      default: st = OK;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/csm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant chosen combinationally from the request
// vector, searching upward from a pointer that moves past each granted port.
module csm_rr_arbiter
  import csm_pkg::*;
#(
  parameter int NPORTS = 2,
  localparam int IW = idx_width(NPORTS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NPORTS-1:0] req,
  output logic [NPORTS-1:0] grant,
  output logic [IW-1:0]     grant_idx,
  output logic              grant_any
);

  logic [IW-1:0] ptr;

  always_comb begin
    logic [IW-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < NPORTS; i++) begin
      cand = IW'((int'(ptr) + i) % NPORTS);
      if (!grant_any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (int'(grant_idx) == NPORTS - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/csm_multiport.sv
// Shared register file for several processors with per-address ownership locks,
// optional idle-timeout auto-release, and one granted request per cycle.
module csm_multiport
  import csm_pkg::*;
#(
  parameter int NPORTS       = 2,
  parameter int DEPTH        = 4,
  parameter int DW           = 8,
  parameter int HOLD_TIMEOUT = 0,
  localparam int AW = idx_width(DEPTH),
  localparam int IW = idx_width(NPORTS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NPORTS-1:0]          req_valid,
  output logic [NPORTS-1:0]          req_ready,
  input  logic [NPORTS-1:0][1:0]     req_op,
  input  logic [NPORTS-1:0][AW-1:0]  req_addr,
  input  logic [NPORTS-1:0][DW-1:0]  req_wdata,
  output logic [NPORTS-1:0]          rsp_valid,
  output logic [NPORTS-1:0][1:0]     rsp_status,
  output logic [NPORTS-1:0][DW-1:0]  rsp_rdata,
  output logic [DEPTH-1:0]           lock_timeout
);

  localparam int CW = idx_width(HOLD_TIMEOUT);

  logic [NPORTS-1:0] grant;
  logic [IW-1:0]     grant_idx;
  logic              grant_any;

  logic [DW-1:0]     mem      [DEPTH];
  logic [DEPTH-1:0]  locked;
  logic [IW-1:0]     owner    [DEPTH];
  logic [CW-1:0]     idle_cnt [DEPTH];
  logic [DEPTH-1:0]  expire;

  op_t               sel_op;
  logic [AW-1:0]     sel_addr;
  logic [DW-1:0]     sel_wdata;
  logic              in_range;
  logic              eff_locked;
  logic              owned;
  status_t           sel_status;
  logic [DW-1:0]     sel_rdata;
  logic              op_ok;

  // Holding reset also suppresses grants so nothing is accepted mid-reset.
  csm_rr_arbiter #(.NPORTS(NPORTS)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req_valid & {NPORTS{reset_n}}),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = grant;

  always_comb begin
    expire = '0;
    for (int a = 0; a < DEPTH; a++) begin
      expire[a] = (HOLD_TIMEOUT > 0) && locked[a] &&
                  (idle_cnt[a] == CW'(HOLD_TIMEOUT - 1));
    end
  end

  // Expiry is applied before the granted op is judged, so an op landing on
  // an expiring address sees it unlocked.
  always_comb begin
    sel_op     = op_t'(req_op[grant_idx]);
    sel_addr   = req_addr[grant_idx];
    sel_wdata  = req_wdata[grant_idx];
    in_range   = (int'(sel_addr) < DEPTH);
    eff_locked = 1'b0;
    owned      = 1'b0;
    sel_rdata  = '0;
    if (in_range) begin
      eff_locked = locked[sel_addr] & ~expire[sel_addr];
      owned      = eff_locked && (owner[sel_addr] == grant_idx);
    end
    sel_status = in_range ? lock_check(sel_op, eff_locked, owned) : ERR_LOCKED;
    op_ok      = grant_any && in_range && (sel_status == OK);
    if (op_ok && sel_op == READ) begin
      sel_rdata = mem[sel_addr];
    end
  end

  // Lock table, idle counters and memory; later assignments to the target
  // address override the default count/expiry update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem[a]      <= '0;
        owner[a]    <= '0;
        idle_cnt[a] <= '0;
      end
      locked       <= '0;
      lock_timeout <= '0;
    end else begin
      lock_timeout <= expire;
      for (int a = 0; a < DEPTH; a++) begin
        if (expire[a]) begin
          locked[a]   <= 1'b0;
          idle_cnt[a] <= '0;
        end else if (locked[a]) begin
          idle_cnt[a] <= idle_cnt[a] + 1'b1;
        end
      end
      if (op_ok) begin
        case (sel_op)
          READ: begin
            if (owned) idle_cnt[sel_addr] <= '0;
          end
          WRITE: begin
            mem[sel_addr] <= sel_wdata;
            if (owned) idle_cnt[sel_addr] <= '0;
          end
          HOLD: begin
            locked[sel_addr]   <= 1'b1;
            owner[sel_addr]    <= grant_idx;
            idle_cnt[sel_addr] <= '0;
          end
          RELEASE: begin
            locked[sel_addr]   <= 1'b0;
            idle_cnt[sel_addr] <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid  <= '0;
      rsp_status <= '0;
      rsp_rdata  <= '0;
    end else begin
      rsp_valid <= grant;
      for (int p = 0; p < NPORTS; p++) begin
        rsp_status[p] <= grant[p] ? sel_status : OK;
        rsp_rdata[p]  <= grant[p] ? sel_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_csm_multiport.sv
// Scoreboard bench for csm_multiport: a lock-table model predicts grants,
// responses and timeout pulses; a monitor compares them as the DUT produces them.
module tb_csm_multiport;
  import csm_pkg::*;

  localparam int NP  = 2;
  localparam int DEP = 4;
  localparam int DW  = 8;
  localparam int HT  = 8;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [NP-1:0]           req_valid = '0;
  logic [NP-1:0]           req_ready;
  logic [NP-1:0][1:0]      req_op = '0;
  logic [NP-1:0][1:0]      req_addr = '0;
  logic [NP-1:0][DW-1:0]   req_wdata = '0;
  logic [NP-1:0]           rsp_valid;
  logic [NP-1:0][1:0]      rsp_status;
  logic [NP-1:0][DW-1:0]   rsp_rdata;
  logic [DEP-1:0]          lock_timeout;

  typedef struct {
    int         port;
    logic [1:0] status;
    logic [7:0] rdata;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] tq[$];
  int         errors = 0;
  int         checks = 0;

  int         m_owner[DEP];
  int         m_idle[DEP];
  logic [7:0] m_mem[DEP];
  int         m_rr;

  always #5 clk = ~clk;

  csm_multiport #(.NPORTS(NP), .DEPTH(DEP), .DW(DW), .HOLD_TIMEOUT(HT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_rdata    (rsp_rdata),
    .lock_timeout (lock_timeout)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int a = 0; a < DEP; a++) begin
      m_owner[a] = -1;
      m_idle[a]  = 0;
      m_mem[a]   = 8'h00;
    end
    m_rr = 0;
    sb.delete();
    tq.delete();
  endtask

  // One cycle of the reference: owner -1 means free; idle counts untouched cycles.
  task automatic modelStep();
    logic [3:0] to_vec;
    int   g;
    int   a;
    int   p;
    int   touched;
    exp_t e;
    to_vec  = 4'd0;
    g       = -1;
    touched = -1;
    for (int i = 0; i < DEP; i++) begin
      if (m_owner[i] >= 0 && m_idle[i] == HT - 1) begin
        m_owner[i] = -1;
        m_idle[i]  = 0;
        to_vec[i]  = 1'b1;
      end
    end
    for (int i = 0; i < NP; i++) begin
      p = (m_rr + i) % NP;
      if (g < 0 && req_valid[p]) g = p;
    end
    checkOutput("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    if (g >= 0) begin
      a       = int'(req_addr[g]);
      e.port  = g;
      e.rdata = 8'h00;
      e.status = OK;
      case (op_t'(req_op[g]))
        READ, WRITE: begin
          if (m_owner[a] < 0 || m_owner[a] == g) begin
            if (op_t'(req_op[g]) == READ) e.rdata = m_mem[a];
            else m_mem[a] = req_wdata[g];
            if (m_owner[a] == g) touched = a;
          end else begin
            e.status = ERR_LOCKED;
          end
        end
        HOLD: begin
          if (m_owner[a] < 0 || m_owner[a] == g) begin
            m_owner[a] = g;
            touched    = a;
          end else begin
            e.status = ERR_LOCKED;
          end
        end
        default: begin
          if (m_owner[a] < 0) e.status = ERR_NOT_HELD;
          else if (m_owner[a] != g) e.status = ERR_NOT_OWNER;
          else begin
            m_owner[a] = -1;
            touched    = a;
          end
        end
      endcase
      sb.push_back(e);
      m_rr = (g + 1) % NP;
    end
    for (int i = 0; i < DEP; i++) begin
      if (i == touched) m_idle[i] = 0;
      else if (m_owner[i] >= 0) m_idle[i]++;
    end
    tq.push_back(to_vec);
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [1:0] op0, input logic [1:0] a0,
                               input logic [7:0] d0,
                               input logic [1:0] op1, input logic [1:0] a1,
                               input logic [7:0] d1);
    @(negedge clk);
    req_valid    = v;
    req_op[0]    = op0;
    req_addr[0]  = a0;
    req_wdata[0] = d0;
    req_op[1]    = op1;
    req_addr[1]  = a1;
    req_wdata[1] = d1;
    #1;
    modelStep();
  endtask

  task automatic p0(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
    applyStimulus(2'b01, op, a, d, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic p1(input logic [1:0] op, input logic [1:0] a, input logic [7:0] d);
    applyStimulus(2'b10, 2'd0, 2'd0, 8'h00, op, a, d);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(2'b00, 2'd0, 2'd0, 8'h00, 2'd0, 2'd0, 8'h00);
  endtask

  task automatic resetMidRequest();
    @(negedge clk);
    req_valid   = 2'b01;
    req_op[0]   = READ;
    req_addr[0] = 2'd0;
    #2 reset_n = 1'b0;
    #1 checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    modelReset();
  endtask

  // Monitor: checks every cycle just after the active edge.
  initial begin
    exp_t       e;
    logic [3:0] exp_to;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_status", 32'(rsp_status), 32'd0);
        checkOutput("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
        checkOutput("reset_lock_timeout", 32'(lock_timeout), 32'd0);
      end else begin
        exp_to = (tq.size() != 0) ? tq.pop_front() : 4'd0;
        checkOutput("lock_timeout", 32'(lock_timeout), 32'(exp_to));
        if (rsp_valid != '0) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_rsp: got rsp_valid=0x%0h, expected none", rsp_valid);
          end else begin
            e = sb.pop_front();
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1 << e.port);
            checkOutput("rsp_status", 32'(rsp_status[e.port]), 32'(e.status));
            checkOutput("rsp_rdata", 32'(rsp_rdata[e.port]), 32'(e.rdata));
          end
        end else if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          errors++;
          $display("[TB] FAIL missing_rsp: got rsp_valid=0x0, expected port %0d response", e.port);
        end
        for (int p = 0; p < NP; p++) begin
          if (!rsp_valid[p]) checkOutput("idle_port_zero", {22'd0, rsp_status[p], rsp_rdata[p]}, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    p0(WRITE, 2'd2, 8'hA5);
    p0(READ, 2'd2, 8'h00);

    p0(HOLD, 2'd1, 8'h00);
    p1(READ, 2'd1, 8'h00);
    p1(WRITE, 2'd1, 8'hFF);
    p0(READ, 2'd1, 8'h00);
    p1(RELEASE, 2'd1, 8'h00);

    p0(HOLD, 2'd1, 8'h00);
    p0(RELEASE, 2'd1, 8'h00);
    p1(READ, 2'd1, 8'h00);
    p0(RELEASE, 2'd1, 8'h00);

    repeat (6) applyStimulus(2'b11, READ, 2'd2, 8'h00, READ, 2'd0, 8'h00);

    p0(HOLD, 2'd3, 8'h00);
    idleCycles(8);
    p1(HOLD, 2'd3, 8'h00);
    p1(RELEASE, 2'd3, 8'h00);

    // Non-owner op landing exactly on the expiry cycle sees the address free.
    p0(HOLD, 2'd2, 8'h00);
    idleCycles(7);
    p1(WRITE, 2'd2, 8'h33);
    p0(READ, 2'd2, 8'h00);

    // Owner activity restarts the idle count.
    p0(HOLD, 2'd0, 8'h00);
    idleCycles(6);
    p0(READ, 2'd0, 8'h00);
    idleCycles(7);
    p1(READ, 2'd0, 8'h00);
    idleCycles(2);

    p0(WRITE, 2'd0, 8'h5A);
    p0(HOLD, 2'd0, 8'h00);
    resetMidRequest();
    p1(READ, 2'd0, 8'h00);

    for (int c = 0; c < 400; c++) begin
      if (c % 64 == 63) idleCycles(10);
      applyStimulus(2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
    end

    idleCycles(2);
    @(posedge clk);
    #2;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
